// File: rtl/spart_bus_responder.sv
// SPART bus responder: bus decode, baud divisor, 8N1 transmitter and 16x-oversampled receiver.
// Optional build macro SPART_ERR_FLAGS_EN adds sticky framing/overrun status bits.
module spart_bus_responder #(
   parameter logic [15:0] DIV_RESET   = 16'h0145,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} fsm_t;

   localparam logic [1:0] A_DATA   = 2'b00;
   localparam logic [1:0] A_STATUS = 2'b01;
   localparam logic [1:0] A_DIV_LO = 2'b10;
   localparam logic [1:0] A_DIV_HI = 2'b11;

   logic wr_data, wr_lo, wr_hi, rd_data, rd_status;
   assign wr_data   = iocs & ~iorw & (ioaddr == A_DATA);
   assign wr_lo     = iocs & ~iorw & (ioaddr == A_DIV_LO);
   assign wr_hi     = iocs & ~iorw & (ioaddr == A_DIV_HI);
   assign rd_data   = iocs &  iorw & (ioaddr == A_DATA);
   assign rd_status = iocs &  iorw & (ioaddr == A_STATUS);

   // ---------------- baud generator ----------------
   logic [15:0] divisor, div_next, baud_cnt;
   logic        en16;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      div_next = divisor;
      if (wr_lo) div_next[7:0]  = databus;
      if (wr_hi) div_next[15:8] = databus;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         divisor  <= DIV_RESET;
         baud_cnt <= DIV_RESET;
      end else begin
         divisor <= div_next;
         if (wr_lo || wr_hi)     baud_cnt <= div_next;
         else if (baud_cnt == '0) baud_cnt <= divisor;
         else                     baud_cnt <= baud_cnt - 16'd1;
      end
   end

   assign en16 = (baud_cnt == '0);

   // ---------------- transmitter ----------------
   fsm_t       tx_state, tx_next;
   logic       tx_pending;
   logic [7:0] tx_shift;
   logic [3:0] tx_tick;
   logic [2:0] tx_bit;
   logic       tx_last_tick;

   assign tx_last_tick = en16 && (tx_tick == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) tx_state <= S_IDLE;
      else     tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         S_IDLE:  if (tx_pending && en16)                 tx_next = S_START;
         S_START: if (tx_last_tick)                       tx_next = S_DATA;
         S_DATA:  if (tx_last_tick && tx_bit == 3'd7)     tx_next = S_STOP;
         S_STOP:  if (tx_last_tick)                       tx_next = S_IDLE;
         default:                                         tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_pending <= 1'b0;
         tx_shift   <= '0;
         tx_tick    <= '0;
         tx_bit     <= '0;
      end else begin
         // A write while busy is dropped; tbr already excludes that case.
         if (wr_data && tbr) begin
            tx_shift   <= databus;
            tx_pending <= 1'b1;
         end else if (tx_state == S_IDLE && tx_next == S_START) begin
            tx_pending <= 1'b0;
         end
         if (tx_state == S_IDLE)  tx_tick <= '0;
         else if (en16)           tx_tick <= tx_tick + 4'd1;
         if (tx_state == S_DATA && tx_last_tick) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
         end
      end
   end

   always_comb begin
      tbr = (tx_state == S_IDLE) && !tx_pending;
      unique case (tx_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = tx_shift[0];
         default: txd = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   logic [SYNC_STAGES-1:0] rx_sync;
   logic       rx_s, rx_prev, rx_fall;
   fsm_t       rx_state, rx_next;
   logic [3:0] rx_tick;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift, rx_buf;
   logic       rx_stop_eval, rx_load;

   assign rx_s         = rx_sync[SYNC_STAGES-1];
   assign rx_fall      = rx_prev & ~rx_s;
   assign rx_stop_eval = (rx_state == S_STOP) && en16 && (rx_tick == 4'd15);
   assign rx_load      = rx_stop_eval && rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync  <= '1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
      end else begin
         rx_sync  <= {rx_sync[SYNC_STAGES-2:0], rxd};
         rx_prev  <= rx_s;
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         S_IDLE:  if (rx_fall)                                rx_next = S_START;
         S_START: if (en16 && rx_tick == 4'd7)                rx_next = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (en16 && rx_tick == 4'd15 && rx_bit == 3'd7) rx_next = S_STOP;
         S_STOP:  if (rx_stop_eval)                           rx_next = S_IDLE;
         default:                                             rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_tick  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_buf   <= '0;
         rda      <= 1'b0;
      end else begin
         // Ticks restart on every state change; the half-bit START wait centres later samples.
         if (rx_state == S_IDLE)  rx_tick <= '0;
         else if (en16)           rx_tick <= (rx_next != rx_state) ? 4'd0 : rx_tick + 4'd1;
         if (rx_state == S_DATA && en16 && rx_tick == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
         if (rx_load) begin
            rx_buf <= rx_shift;
            rda    <= 1'b1;
         end else if (rd_data) begin
            rda <= 1'b0;
         end
      end
   end

   // ---------------- status and read mux ----------------
   logic [7:0] status, rd_mux;

`ifdef SPART_ERR_FLAGS_EN
   logic ferr, ovr;
   always_ff @(posedge clk) begin
      if (rst) begin
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         if (rx_stop_eval && !rx_s) ferr <= 1'b1;
         else if (rd_status)        ferr <= 1'b0;
         if (rx_load && rda)        ovr  <= 1'b1;
         else if (rd_status)        ovr  <= 1'b0;
      end
   end
   assign status = {4'b0, ovr, ferr, tbr, rda};
`else
   assign status = {6'b0, tbr, rda};
`endif

   always_comb begin
      rd_mux = 8'h00;
      unique case (ioaddr)
         A_DATA:   rd_mux = rx_buf;
         A_STATUS: rd_mux = status;
         A_DIV_LO: rd_mux = divisor[7:0];
         A_DIV_HI: rd_mux = divisor[15:8];
         default:  rd_mux = 8'h00;
      endcase
   end

   assign databus = (iocs && iorw) ? rd_mux : 8'hzz;

endmodule

// File: tb/tb_spart_bus_responder.sv
// Scoreboard bench for spart_bus_responder: bus reads and TX frames are queued as expectations
// and checked by independent monitors.
module tb_spart_bus_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda, tbr, txd;
   logic       rxd;
   logic [7:0] tb_data;
   logic       tb_drv;

   assign databus = tb_drv ? tb_data : 8'hzz;

   spart_bus_responder dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus),
      .rda     (rda),
      .tbr     (tbr),
      .txd     (txd),
      .rxd     (rxd)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] tx_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         tx_frames = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      iocs = 1'b1; iorw = 1'b0; ioaddr = addr; tb_data = data; tb_drv = 1'b1;
      @(posedge clk); #1;
      iocs = 1'b0; iorw = 1'b1; tb_drv = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
      rd_q.push_back('{name, exp});
      @(posedge clk); #1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
      @(posedge clk); #1;
      iocs = 1'b0;
   endtask

   // One 8N1 frame at divisor 3: 16 en16 of 4 clk = 64 clk per bit.
   task automatic send_rx(input logic [7:0] data, input logic stop_bit);
      rxd = 1'b0;
      repeat (64) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (64) @(posedge clk);
      end
      rxd = stop_bit;
      repeat (64) @(posedge clk);
      rxd = 1'b1;
      repeat (16) @(posedge clk);
   endtask

   // Bus read monitor: the DUT presents read data whenever iocs&iorw.
   always @(negedge clk) begin
      if (iocs && iorw) begin
         if (rd_q.size() == 0) begin
            check("rd_unexpected", {24'b0, databus}, 32'hffff_ffff);
         end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check(e.name, {24'b0, databus}, {24'b0, e.exp});
         end
      end
   end

   // TX monitor: samples each bit at its centre and times tbr from the start edge.
   initial begin : tx_mon
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && txd === 1'b0) begin
            if (tx_q.size() == 0) begin
               check("tx_unexpected_frame", {31'b0, txd}, 32'd1);
               for (int w = 0; w < 2000 && tbr !== 1'b1; w++) @(negedge clk);
            end else begin
               logic [7:0] exp_byte, got;
               int n;
               exp_byte = tx_q.pop_front();
               got = 8'h00;
               n = 0;
               while (tbr !== 1'b1 && n < 2000) begin
                  @(negedge clk);
                  n++;
                  if (n % 64 == 32 && n <= 608) begin
                     int k;
                     k = (n - 32) / 64;
                     if (k == 0)      check("tx_start_bit", {31'b0, txd}, 32'd0);
                     else if (k == 9) check("tx_stop_bit", {31'b0, txd}, 32'd1);
                     else             got[k-1] = txd;
                  end
               end
               check("tx_byte", {24'b0, got}, {24'b0, exp_byte});
               check("tbr_latency", n, 640);
               tx_frames++;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
      tb_data = 8'h00; tb_drv = 1'b0; rxd = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("reset_txd", {31'b0, txd}, 32'd1);
      check("reset_tbr", {31'b0, tbr}, 32'd1);
      check("reset_rda", {31'b0, rda}, 32'd0);
      check("bus_z_idle", {31'b0, (databus === 8'hzz)}, 32'd1);
      bus_read(2'b10, 8'h45, "div_lo_reset");
      bus_read(2'b11, 8'h01, "div_hi_reset");
      bus_read(2'b01, 8'h02, "status_reset");
      bus_read(2'b00, 8'h00, "rxbuf_reset");

      // Divisor to 3; status writes are ignored
      bus_write(2'b10, 8'h03);
      bus_write(2'b11, 8'h00);
      bus_write(2'b01, 8'hFF);
      bus_read(2'b10, 8'h03, "div_lo_new");
      bus_read(2'b11, 8'h00, "div_hi_new");
      bus_read(2'b01, 8'h02, "status_after_wr01");

      // Transmit A5; a write while busy must be dropped
      tx_q.push_back(8'hA5);
      bus_write(2'b00, 8'hA5);
      check("tbr_after_write", {31'b0, tbr}, 32'd0);
      repeat (100) @(posedge clk);
      bus_write(2'b00, 8'h11);
      for (int w = 0; w < 2000 && tx_frames < 1; w++) @(posedge clk);
      check("tx_frame_count", tx_frames, 1);
      repeat (300) @(posedge clk);
      check("tbr_idle_after", {31'b0, tbr}, 32'd1);
      check("txd_idle_after", {31'b0, txd}, 32'd1);

      // Receive 3C
      send_rx(8'h3C, 1'b1);
      check("rda_set_3c", {31'b0, rda}, 32'd1);
      bus_read(2'b01, 8'h03, "status_rda");
      bus_read(2'b00, 8'h3C, "rx_3c");
      check("rda_cleared", {31'b0, rda}, 32'd0);

      // False start: 16 clk low pulse
      rxd = 1'b0;
      repeat (16) @(posedge clk);
      rxd = 1'b1;
      repeat (200) @(posedge clk);
      check("false_start_rda", {31'b0, rda}, 32'd0);

      // Framing error on 55
      send_rx(8'h55, 1'b0);
      check("framing_rda", {31'b0, rda}, 32'd0);
`ifdef SPART_ERR_FLAGS_EN
      bus_read(2'b01, 8'h06, "status_framing");
`else
      bus_read(2'b01, 8'h02, "status_framing");
`endif
      bus_read(2'b01, 8'h02, "status_framing_cleared");
      bus_read(2'b00, 8'h3C, "rxbuf_kept");

      // Overrun: two frames without a read
      send_rx(8'h12, 1'b1);
      send_rx(8'h34, 1'b1);
      check("rda_overrun", {31'b0, rda}, 32'd1);
`ifdef SPART_ERR_FLAGS_EN
      bus_read(2'b01, 8'h0B, "status_overrun");
`else
      bus_read(2'b01, 8'h03, "status_overrun");
`endif
      bus_read(2'b00, 8'h34, "rx_second_byte");
      bus_read(2'b01, 8'h02, "status_final");

      repeat (10) @(posedge clk);
      check("rd_queue_drained", rd_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
